// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD digit type, constants, controller states and digit check
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_ADJ = 4'd6;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } bcd_ser_state_t;

  function automatic logic is_bcd(input bcd_digit_t digit);
    return digit <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// rtl/bcd_digit_adder.sv - combinational single-digit BCD adder slice with decimal carry
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       bad
);

  logic [4:0] s5;

  always_comb begin
    s5  = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
    s   = s5[3:0];
    co  = 1'b0;
    // Adding 6 modulo 16 skips the six unused codes and yields the decimal digit.
    if (s5 > {1'b0, BCD_MAX}) begin
      s  = s5[3:0] + BCD_ADJ;
      co = 1'b1;
    end
    bad = !is_bcd(a) || !is_bcd(b);
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// rtl/bcd_serial_adder.sv - multi-digit BCD adder reusing one digit slice, LSD first
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] a,
  input  logic [4*NDIG-1:0] b,
  input  logic              cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] sum,
  output logic              cout,
  output logic              err
);

  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

  bcd_ser_state_t    state;
  logic [4*NDIG-1:0] a_q;
  logic [4*NDIG-1:0] b_q;
  logic [4*NDIG-1:0] sum_q;
  logic [IDX_W-1:0]  idx;
  logic              carry;
  logic              cout_q;
  logic              err_q;
  logic              out_valid_q;

  bcd_digit_t        dig_a;
  bcd_digit_t        dig_b;
  bcd_digit_t        dig_s;
  logic              dig_co;
  logic              dig_bad;

  assign dig_a = a_q[{idx, 2'b00} +: 4];
  assign dig_b = b_q[{idx, 2'b00} +: 4];

  bcd_digit_adder u_digit (
    .a   (dig_a),
    .b   (dig_b),
    .ci  (carry),
    .s   (dig_s),
    .co  (dig_co),
    .bad (dig_bad)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx         <= '0;
      carry       <= 1'b0;
      cout_q      <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q    <= a;
            b_q    <= b;
            carry  <= cin;
            idx    <= '0;
            err_q  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            state  <= ADD;
          end
        end
        ADD: begin
          sum_q[{idx, 2'b00} +: 4] <= dig_s;
          carry <= dig_co;
          if (dig_bad) begin
            err_q <= 1'b1;
          end
          // Result is presented on the same edge the last digit is written.
          if (idx == LAST_IDX) begin
            cout_q      <= dig_co;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign err       = err_q;

endmodule
